cache_miss_controller: RTL and testbench

//  Request sequencer upstream of the 4-way set-associative cache array. Accepts one CPU

---
 rtl/cache_miss_controller_pkg.sv | 22 ++
 rtl/cache_miss_controller_replacer.sv | 26 ++
 rtl/cache_miss_controller.sv | 152 +++++++++++++++
 tb/tb_cache_miss_controller.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_miss_controller_pkg.sv
// rtl/cache_miss_controller_pkg.sv - shared geometry and state encoding for the cache miss controller
package cache_miss_controller_pkg;

    localparam int NUM_WAYS  = 4;
    localparam int WAY_W     = $clog2(NUM_WAYS);
    localparam int NUM_SETS  = 32;
    localparam int SET_W     = $clog2(NUM_SETS);
    localparam int INDEX_LSB = 5;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOOKUP   = 3'd1,
        ST_CWRITE   = 3'd2,
        ST_MEM_REQ  = 3'd3,
        ST_MEM_WAIT = 3'd4,
        ST_FILL     = 3'd5,
        ST_RESP     = 3'd6
    } state_t;

endpackage

// File: rtl/cache_miss_controller_replacer.sv
// rtl/cache_miss_controller_replacer.sv - per-set round-robin victim pointers
module cache_miss_controller_replacer
    import cache_miss_controller_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [SET_W-1:0] set_idx,
    input  logic             advance,
    output logic [WAY_W-1:0] way
);

    logic [WAY_W-1:0] ptr [NUM_SETS];

    assign way = ptr[set_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SETS; i++) begin
                ptr[i] <= '0;
            end
        end else if (advance) begin
            ptr[set_idx] <= (ptr[set_idx] == WAY_W'(NUM_WAYS - 1)) ? '0 : ptr[set_idx] + 1'b1;
        end
    end

endmodule

// File: rtl/cache_miss_controller.sv
// rtl/cache_miss_controller.sv - CPU request sequencer with miss refill and write-through stores
module cache_miss_controller
    import cache_miss_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_we,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    output logic              cpu_resp_valid,
    output logic [DATA_W-1:0] cpu_resp_rdata,
    output logic              cache_read,
    output logic              cache_write,
    output logic [ADDR_W-1:0] cache_address,
    output logic [DATA_W-1:0] cache_write_data,
    output logic [WAY_W-1:0]  cache_replace_way,
    input  logic [DATA_W-1:0] cache_read_data,
    input  logic              cache_hit,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_wdata,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_rdata
);

    state_t            state;
    state_t            state_next;
    logic              we_q;
    logic              hit_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] fetched_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic [SET_W-1:0]  set_idx;
    logic              rr_advance;
    logic [WAY_W-1:0]  rr_way;

    assign set_idx        = addr_q[INDEX_LSB +: SET_W];
    assign cache_address  = addr_q;
    assign cpu_resp_rdata = resp_rdata_q;

    cache_miss_controller_replacer u_replacer (
        .clk     (clk),
        .reset   (reset),
        .set_idx (set_idx),
        .advance (rr_advance),
        .way     (rr_way)
    );

    // resp_rdata_q is only loaded on the transition into RESP so it holds between responses
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            we_q         <= 1'b0;
            hit_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            fetched_q    <= '0;
            resp_rdata_q <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (cpu_req_valid) begin
                        we_q    <= cpu_req_we;
                        addr_q  <= cpu_req_addr;
                        wdata_q <= cpu_req_wdata;
                    end
                end
                ST_LOOKUP: begin
                    hit_q <= cache_hit;
                    if (!we_q && cache_hit) begin
                        resp_rdata_q <= cache_read_data;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_resp_valid) begin
                        if (we_q) begin
                            resp_rdata_q <= '0;
                        end else begin
                            fetched_q <= mem_resp_rdata;
                        end
                    end
                end
                ST_FILL: resp_rdata_q <= fetched_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next        = state;
        cpu_req_ready     = 1'b0;
        cpu_resp_valid    = 1'b0;
        cache_read        = 1'b0;
        cache_write       = 1'b0;
        cache_write_data  = '0;
        cache_replace_way = '0;
        mem_req_valid     = 1'b0;
        mem_req_we        = 1'b0;
        mem_req_addr      = '0;
        mem_req_wdata     = '0;
        rr_advance        = 1'b0;
        case (state)
            ST_IDLE: begin
                cpu_req_ready = 1'b1;
                if (cpu_req_valid) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                cache_read = 1'b1;
                if (we_q)           state_next = ST_CWRITE;
                else if (cache_hit) state_next = ST_RESP;
                else                state_next = ST_MEM_REQ;
            end
            ST_CWRITE: begin
                // write-allocate: a store miss claims the victim way and moves the pointer on
                cache_write       = 1'b1;
                cache_write_data  = wdata_q;
                cache_replace_way = rr_way;
                rr_advance        = !hit_q;
                state_next        = ST_MEM_REQ;
            end
            ST_MEM_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_we    = we_q;
                mem_req_addr  = addr_q;
                mem_req_wdata = we_q ? wdata_q : '0;
                if (mem_req_ready) state_next = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (mem_resp_valid) state_next = we_q ? ST_RESP : ST_FILL;
            end
            ST_FILL: begin
                cache_write       = 1'b1;
                cache_write_data  = fetched_q;
                cache_replace_way = rr_way;
                rr_advance        = 1'b1;
                state_next        = ST_RESP;
            end
            ST_RESP: begin
                cpu_resp_valid = 1'b1;
                state_next     = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_miss_controller.sv
// tb/tb_cache_miss_controller.sv - scoreboard bench with array and delayed-memory models
module tb_cache_miss_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0] cpu_req_addr, cpu_req_wdata;
    logic        cpu_resp_valid;
    logic [31:0] cpu_resp_rdata;
    logic        cache_read, cache_write;
    logic [31:0] cache_address, cache_write_data;
    logic [1:0]  cache_replace_way;
    logic [31:0] cache_read_data;
    logic        cache_hit;
    logic        mem_req_valid, mem_req_we;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_rdata = 32'h0;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    cache_miss_controller dut (
        .clk               (clk),
        .reset             (reset),
        .cpu_req_valid     (cpu_req_valid),
        .cpu_req_ready     (cpu_req_ready),
        .cpu_req_we        (cpu_req_we),
        .cpu_req_addr      (cpu_req_addr),
        .cpu_req_wdata     (cpu_req_wdata),
        .cpu_resp_valid    (cpu_resp_valid),
        .cpu_resp_rdata    (cpu_resp_rdata),
        .cache_read        (cache_read),
        .cache_write       (cache_write),
        .cache_address     (cache_address),
        .cache_write_data  (cache_write_data),
        .cache_replace_way (cache_replace_way),
        .cache_read_data   (cache_read_data),
        .cache_hit         (cache_hit),
        .mem_req_valid     (mem_req_valid),
        .mem_req_ready     (mem_req_ready),
        .mem_req_we        (mem_req_we),
        .mem_req_addr      (mem_req_addr),
        .mem_req_wdata     (mem_req_wdata),
        .mem_resp_valid    (mem_resp_valid),
        .mem_resp_rdata    (mem_resp_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // 4-way array: 5-bit set index at [9:5], tag above it
    logic        arr_clear;
    logic        arr_valid [32][4];
    logic [21:0] arr_tag   [32][4];
    logic [31:0] arr_data  [32][4];
    logic [4:0]  a_set;
    logic [21:0] a_tag;
    assign a_set = cache_address[9:5];
    assign a_tag = cache_address[31:10];

    always_comb begin
        cache_hit       = 1'b0;
        cache_read_data = 32'h0;
        if (cache_read) begin
            for (int w = 0; w < 4; w++) begin
                if (arr_valid[a_set][w] && arr_tag[a_set][w] == a_tag) begin
                    cache_hit       = 1'b1;
                    cache_read_data = arr_data[a_set][w];
                end
            end
        end
    end

    always @(posedge clk) begin : array_write
        bit found;
        found = 1'b0;
        if (arr_clear) begin
            for (int s = 0; s < 32; s++)
                for (int w = 0; w < 4; w++) arr_valid[s][w] <= 1'b0;
        end else if (cache_write) begin
            for (int w = 0; w < 4; w++) begin
                if (arr_valid[a_set][w] && arr_tag[a_set][w] == a_tag) begin
                    arr_data[a_set][w] <= cache_write_data;
                    found = 1'b1;
                end
            end
            if (!found) begin
                arr_valid[a_set][cache_replace_way] <= 1'b1;
                arr_tag[a_set][cache_replace_way]   <= a_tag;
                arr_data[a_set][cache_replace_way]  <= cache_write_data;
            end
        end
    end

    // memory with programmable accept and response delays
    int          ready_delay = 0;
    int          resp_delay  = 0;
    bit          m_acc  = 1'b0;
    bit          m_pend = 1'b0;
    int          m_wait = 0;
    int          m_rcnt = 0;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] mem_store [logic [31:0]];
    logic [31:0] ref_mem   [logic [31:0]];

    always begin
        @(posedge clk);
        #1;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = 32'h0;
        if (m_acc) begin
            m_acc  = 1'b0;
            m_pend = 1'b1;
            m_rcnt = resp_delay;
        end
        if (m_pend) begin
            if (m_rcnt == 0) begin
                mem_resp_valid = 1'b1;
                if (!m_we && mem_store.exists(m_addr)) mem_resp_rdata = mem_store[m_addr];
                m_pend = 1'b0;
            end else begin
                m_rcnt--;
            end
        end else if (mem_req_valid) begin
            if (m_wait >= ready_delay) begin
                mem_req_ready = 1'b1;
                m_acc  = 1'b1;
                m_wait = 0;
                m_we   = mem_req_we;
                m_addr = mem_req_addr;
                if (mem_req_we) mem_store[mem_req_addr] = mem_req_wdata;
            end else begin
                m_wait++;
            end
        end
    end

    // scoreboard and monitors
    logic [31:0] exp_q [$];
    logic [1:0]  way_q [$];
    int          resp_count   = 0;
    int          resp_cyc     = 0;
    int          mem_resp_cyc = 0;
    int          hs_count     = 0;
    int          overlap_cnt  = 0;
    logic        hs_we;
    logic [31:0] hs_addr, hs_wdata;
    bit          t5_on = 1'b0;
    int          t5_held = 0;
    int          t5_bad  = 0;
    logic [31:0] t5_addr;

    always @(negedge clk) begin
        if (cpu_resp_valid) begin
            resp_count++;
            resp_cyc = cyc;
            check_eq("resp_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check_eq("resp_rdata", cpu_resp_rdata, exp_q.pop_front());
        end
        if (cache_write && way_q.size() != 0)
            check_eq("fill_way", 32'(cache_replace_way), 32'(way_q.pop_front()));
        if (mem_resp_valid) mem_resp_cyc = cyc;
        if (mem_req_valid && mem_req_ready) begin
            hs_count++;
            hs_we    = mem_req_we;
            hs_addr  = mem_req_addr;
            hs_wdata = mem_req_wdata;
        end
        if (t5_on && mem_req_valid && !mem_req_ready) begin
            t5_held++;
            if (mem_req_addr !== t5_addr || mem_req_we !== 1'b0 || cpu_req_ready !== 1'b0) t5_bad++;
        end
        if (cache_read && cache_write) overlap_cnt++;
    end

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] d);
        mem_store[a] = d;
        ref_mem[a]   = d;
    endtask

    task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int acc);
        int n;
        exp_q.push_back(we ? 32'h0 : ref_read(addr));
        if (we) ref_mem[addr] = wdata;
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = addr;
        cpu_req_wdata = wdata;
        n = 0;
        @(negedge clk);
        while (!cpu_req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cpu_req_ready) check_eq("accept_timeout", 32'(cpu_req_ready), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        cpu_req_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n0);
        int n;
        n = 0;
        while (resp_count == n0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (resp_count == n0) check_eq("resp_timeout", 32'(resp_count), 32'(n0 + 1));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] set2_addr(input int tag);
        return (32'(tag) << 10) | 32'h40;
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acc, n0, h0, n, rst_cyc;
        logic [1:0]  victims [5];
        logic [31:0] b_addr, c_addr, d_addr;
        victims = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        b_addr = 32'h80;
        c_addr = 32'h100;
        d_addr = set2_addr(6);

        reset = 1'b1;
        arr_clear = 1'b1;
        cpu_req_valid = 1'b0;
        cpu_req_we = 1'b0;
        cpu_req_addr = 32'h0;
        cpu_req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        arr_clear = 1'b0;
        @(negedge clk);
        check_eq("rst_ready",      32'(cpu_req_ready), 32'd1);
        check_eq("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
        check_eq("rst_resp_rdata", cpu_resp_rdata, 32'h0);
        check_eq("rst_cache_read", 32'(cache_read), 32'd0);
        check_eq("rst_cache_wr",   32'(cache_write), 32'd0);
        check_eq("rst_mem_valid",  32'(mem_req_valid), 32'd0);
        check_eq("rst_repl_way",   32'(cache_replace_way), 32'd0);
        @(posedge clk);
        #1;

        // cold load miss fills way 0
        preload(32'h40, 32'hDEAD_BEEF);
        way_q.push_back(2'd0);
        n0 = resp_count; h0 = hs_count;
        send(1'b0, 32'h40, 32'h0, acc);
        wait_resp(n0);
        check_eq("t1_mem_req", 32'(hs_count - h0), 32'd1);
        check_eq("t1_latency", 32'(resp_cyc - mem_resp_cyc), 32'd2);

        // repeat load hits without memory traffic
        n0 = resp_count; h0 = hs_count;
        send(1'b0, 32'h40, 32'h0, acc);
        wait_resp(n0);
        check_eq("t2_mem_req", 32'(hs_count - h0), 32'd0);
        check_eq("t2_latency", 32'(resp_cyc - acc), 32'd2);

        // five conflicting misses in set 2 walk the round-robin pointer
        for (int t = 1; t <= 5; t++) begin
            preload(set2_addr(t), 32'hA000_0000 + 32'(t));
            way_q.push_back(victims[t-1]);
            n0 = resp_count;
            send(1'b0, set2_addr(t), 32'h0, acc);
            wait_resp(n0);
        end
        n0 = resp_count; h0 = hs_count;
        way_q.push_back(2'd2);
        send(1'b0, set2_addr(1), 32'h0, acc);
        wait_resp(n0);
        check_eq("t3_evicted_miss", 32'(hs_count - h0), 32'd1);
        n0 = resp_count; h0 = hs_count;
        send(1'b0, set2_addr(5), 32'h0, acc);
        wait_resp(n0);
        check_eq("t3_resident_hit", 32'(hs_count - h0), 32'd0);

        // write-through store to a resident line
        preload(b_addr, 32'hB0B0_0001);
        n0 = resp_count;
        send(1'b0, b_addr, 32'h0, acc);
        wait_resp(n0);
        n0 = resp_count;
        send(1'b1, b_addr, 32'h1234_5678, acc);
        wait_resp(n0);
        check_eq("t4_mem_we",    32'(hs_we), 32'd1);
        check_eq("t4_mem_addr",  hs_addr, b_addr);
        check_eq("t4_mem_wdata", hs_wdata, 32'h1234_5678);
        check_eq("t4_latency",   32'(resp_cyc - mem_resp_cyc), 32'd1);
        check_eq("t4_mem_value", mem_store[b_addr], 32'h1234_5678);
        n0 = resp_count; h0 = hs_count;
        send(1'b0, b_addr, 32'h0, acc);
        wait_resp(n0);
        check_eq("t4_reload_hit", 32'(hs_count - h0), 32'd0);

        // memory back-pressure
        ready_delay = 10;
        preload(c_addr, 32'hC0C0_C0C0);
        t5_addr = c_addr; t5_held = 0; t5_bad = 0; t5_on = 1'b1;
        n0 = resp_count;
        send(1'b0, c_addr, 32'h0, acc);
        wait_resp(n0);
        t5_on = 1'b0;
        ready_delay = 0;
        check_eq("t5_held_cycles", 32'(t5_held), 32'd10);
        check_eq("t5_unstable",    32'(t5_bad), 32'd0);

        // reset during MEM_WAIT, late response must be ignored
        resp_delay = 6;
        preload(d_addr, 32'hD00D_F00D);
        n0 = resp_count;
        send(1'b0, d_addr, 32'h0, acc);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(mem_req_valid && mem_req_ready) && n < 50);
        if (!(mem_req_valid && mem_req_ready)) check_eq("t6_handshake_timeout", 32'(mem_req_ready), 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        rst_cyc = cyc;
        @(posedge clk); #1;
        reset = 1'b0;
        if (exp_q.size() != 0) void'(exp_q.pop_back());
        n = 0;
        while ((m_pend || m_acc) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (3) @(negedge clk);
        check_eq("t6_no_resp",    32'(resp_count), 32'(n0));
        check_eq("t6_idle_ready", 32'(cpu_req_ready), 32'd1);
        check_eq("t6_late_resp",  32'(mem_resp_cyc > rst_cyc), 32'd1);
        resp_delay = 0;
        @(posedge clk); #1;
        way_q.push_back(2'd0);
        n0 = resp_count;
        send(1'b0, d_addr, 32'h0, acc);
        wait_resp(n0);
        check_eq("t6_after_reset", 32'(resp_count - n0), 32'd1);

        repeat (3) @(posedge clk);
        check_eq("sb_empty",    32'(exp_q.size()), 32'd0);
        check_eq("way_q_empty", 32'(way_q.size()), 32'd0);
        check_eq("rd_wr_overlap", 32'(overlap_cnt), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
